// File: rtl/lane_serializer.sv
// N-lane to 1-lane word serializer: takes one frame of LANES words with a
// per-lane valid mask and emits it one slot per clock in ascending lane order.
module lane_serializer #(
  parameter int WIDTH        = 8,
  parameter int LANES        = 4,
  parameter bit SKIP_INVALID = 1'b1,
  parameter int LW           = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [LW-1:0]          out_lane,
  output logic                   out_last,
  input  logic                   out_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [LANES*WIDTH-1:0] data_q;
  logic [LANES-1:0]       rem, rem_nxt, lvm, load_rem;
  logic [LW-1:0]          cur;
  logic                   cur_lvm, single, advance, accept;

  function automatic logic [LW-1:0] lowest(input logic [LANES-1:0] m);
    lowest = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest = LW'(i);
    end
  endfunction

  assign cur      = lowest(rem);
  assign out_lane = cur;

  always_comb begin
    out_data = '0;
    cur_lvm  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (cur == LW'(i)) begin
        out_data = data_q[i*WIDTH +: WIDTH];
        cur_lvm  = lvm[i];
      end
    end
  end

  // Exactly one remaining slot means the current slot closes the frame.
  assign single    = (rem != '0) && ((rem & (rem - LANES'(1))) == '0);
  assign out_valid = (state == SEND) && (SKIP_INVALID ? 1'b1 : cur_lvm);
  assign out_last  = (state == SEND) && single;
  assign advance   = (state == SEND) && (out_ready || !out_valid);
  assign in_ready  = (state == IDLE) || (out_last && advance);
  assign accept    = in_valid && in_ready;
  assign load_rem  = SKIP_INVALID ? in_lane_valid : '1;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (advance) begin
      rem_nxt = rem & ~(LANES'(1) << cur);
      if (out_last) state_nxt = IDLE;
    end
    // A frame taken on the final advance overrides the clear, so frames abut.
    if (accept) begin
      rem_nxt   = load_rem;
      state_nxt = (load_rem != '0) ? SEND : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      lvm    <= '0;
    end else if (accept) begin
      data_q <= in_data;
      lvm    <= in_lane_valid;
    end
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Parametrised N-lane to 1-lane byte serializer with per-lane valid, successor to the fixed 4-to-1 8-bit valid multiplexer in the PHY TX path. It accepts one frame of LANES words plus a per-lane valid mask through a ready/valid handshake. It emits the frame one word per clock on a single output, in ascending lane order. A single clock replaces the 1f/2f/4f clock tree, and output backpressure plus optional skipping of invalid lanes are added.

## Interface
Parameters:
- WIDTH, 8, bits per lane word
- LANES, 4, number of input lanes (≥2, power of two not required)
- SKIP_INVALID, 1, 1 = emit only valid lanes; 0 = emit every lane slot, flagging invalid ones
- LW, $clog2(LANES), lane index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_lane_valid  in  LANES  valid mask, bit i for lane i
- in_valid  in  1  frame offered
- in_ready  out  1  block can accept a frame this cycle
- out_data  out  WIDTH  current lane word
- out_valid  out  1  out_data carries a valid word
- out_lane  out  LW  lane index of current slot
- out_last  out  1  current slot is the final slot of the frame
- out_ready  in  1  downstream consumes the current slot

## Operation
- Frame register holds data plus a remaining-slot mask `rem`. State machine has two states: IDLE and SEND.
- Accept: in_valid & in_ready at a rising edge latches in_data.
  - SKIP_INVALID=1: `rem` = in_lane_valid.
  - SKIP_INVALID=0: `rem` = all ones, and the lane mask is stored separately.
  - State goes to SEND if `rem` ≠ 0. Otherwise the state stays IDLE and the frame is silently dropped (only possible with SKIP_INVALID=1).
- Current slot = lowest set bit of `rem` (priority encode). out_lane = that index; out_data = that lane's word.
- out_valid:
  - SKIP_INVALID=1: out_valid = 1 in SEND.
  - SKIP_INVALID=0: out_valid = stored lane-valid bit of the current slot.
- Slot advance occurs on (out_ready | ~out_valid) in SEND: clear the current bit of `rem`. Invalid slots in mode 0 advance without needing out_ready.
- out_last = 1 when `rem` has exactly one bit set in SEND.
- Back-to-back frames: in_ready = IDLE | (SEND & out_last & advance). A frame accepted on the advance of the last slot loads directly, giving zero bubbles between frames.
- IDLE: out_valid=0, out_last=0. out_data and out_lane show the last value and are don't-care.
- Lane words, masks and outputs combine combinationally from registers only. in_ready depends combinationally on out_ready (documented; no comb path from in_* to out_*).

## Timing
- Reset (reset=0, asynchronous): state=IDLE, `rem`=0, data regs=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_lane=0, out_data=0.
- Reset release: in_ready is high from the first edge after reset deasserts.
- Reset asserted mid-frame: the frame is discarded immediately with no further slots. The state returns to the reset values above.
- Latency: frame accepted at edge k → first slot visible on outputs after edge k (cycle k+1), one slot per cycle with out_ready=1.
- Frame of V valid lanes:
  - SKIP_INVALID=1: V cycles.
  - SKIP_INVALID=0: LANES cycles.
- out_ready low holds the current slot; out_data, out_lane, out_valid and out_last stay stable until consumed.
- in_valid held with in_ready=0: the frame is not taken. The source must hold in_data stable.

## Test plan
- Reset: drive reset=0 mid-frame (LANES=4, mask 4'b1111, slot 1 showing) → out_valid=0, in_ready=1 asynchronously. Nothing is emitted after release until a new frame arrives.
- Full frame, SKIP_INVALID=1: in_data={8'hD3,8'hC2,8'hB1,8'hA0}, mask 4'b1111, out_ready=1 → A0,B1,C2,D3 on cycles k+1..k+4, out_lane 0..3, out_last only on D3.
- Skip invalid: mask 4'b1010, same data → B1 (lane 1) then D3 (lane 3, out_last), 2 cycles. Mask 4'b0000 → no output, in_ready stays 1.
- Mode SKIP_INVALID=0, mask 4'b0101 → 4 slots; out_valid=1,0,1,0 with A0 and C2 valid. out_ready=0 stalls only the valid slots.
- Back-to-back with backpressure: two frames offered continuously, out_ready toggling 1,0,1,1… → no slot is lost or duplicated. Frame 2 lane 0 follows frame 1 out_last with no idle cycle when out_ready=1.
- Parameter sweep: LANES=3, WIDTH=16 and LANES=8, WIDTH=8, random masks and out_ready → scoreboard matches in order, lane indices correct.
